// File: rtl/lcd_capture_pkg.sv
// Shared types and sizing for the LCD capture block.
//   DEF_H_PIXELS / DEF_V_LINES : default active frame geometry
//   FB_BYTES                   : bytes per frame bank (4 pixels per byte)
//   OFS_W / FB_AW              : byte-offset width and full bank+offset width
//   Y_W                        : line counter width (saturates, so V_LINES < 255)
//   lcd_shade_t                : 2-bit pixel shade
//   cap_state_t                : capture FSM states
package lcd_capture_pkg;

    localparam int unsigned DEF_H_PIXELS = 160;
    localparam int unsigned DEF_V_LINES  = 144;
    localparam int unsigned FB_BYTES     = DEF_H_PIXELS / 4 * DEF_V_LINES;
    localparam int unsigned OFS_W        = 13;
    localparam int unsigned FB_AW        = OFS_W + 1;
    localparam int unsigned Y_W          = 8;

    typedef enum logic [1:0] {
        SHADE_0 = 2'd0,
        SHADE_1 = 2'd1,
        SHADE_2 = 2'd2,
        SHADE_3 = 2'd3
    } lcd_shade_t;

    typedef enum logic {
        WAIT_VSYNC = 1'b0,
        CAPTURE    = 1'b1
    } cap_state_t;

endpackage

// File: rtl/lcd_capture_if.sv
// LCD stream in, framebuffer write port out.
//   lcd_vsync/lcd_hsync/lcd_pixel/lcd_color : PPU pixel stream
//   fb_addr/fb_data/fb_we                   : framebuffer byte write
//   master : stream source / framebuffer sink side
//   slave  : the capture block
interface lcd_capture_if;
    import lcd_capture_pkg::*;

    logic             lcd_vsync;
    logic             lcd_hsync;
    logic             lcd_pixel;
    lcd_shade_t       lcd_color;
    logic [FB_AW-1:0] fb_addr;
    logic [7:0]       fb_data;
    logic             fb_we;

    modport master (
        output lcd_vsync, lcd_hsync, lcd_pixel, lcd_color,
        input  fb_addr, fb_data, fb_we
    );

    modport slave (
        input  lcd_vsync, lcd_hsync, lcd_pixel, lcd_color,
        output fb_addr, fb_data, fb_we
    );

endinterface

// File: rtl/lcd_capture_px_pack4.sv
// Packs up to four 2bpp pixels into a byte, leftmost pixel in [7:6].
//   clk, rst : clock, async active-low reset
//   push     : accept color into the next free slot
//   flush    : emit whatever is pending (zero-padded), including this push
//   emit_c   : a byte is complete this cycle (full, or flushed partial)
//   byte_c   : that byte
module px_pack4
    import lcd_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       flush,
    input  lcd_shade_t color,
    output logic       emit_c,
    output logic [7:0] byte_c
);

    logic [1:0] cnt;
    logic [7:0] slots;
    logic [2:0] pos_c;

    // Unfilled slots are always zero, so a flushed partial byte is already padded.
    always_comb begin
        pos_c  = 3'd6 - {cnt, 1'b0};
        byte_c = slots;
        if (push) begin
            byte_c[pos_c +: 2] = color;
        end
        emit_c = flush ? (push || (cnt != 2'd0)) : (push && (cnt == 2'd3));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 2'd0;
            slots <= 8'd0;
        end else if (emit_c) begin
            cnt   <= 2'd0;
            slots <= 8'd0;
        end else if (push) begin
            cnt   <= cnt + 2'd1;
            slots <= byte_c;
        end
    end

endmodule

// File: rtl/lcd_capture.sv
// Captures the PPU LCD stream into a double-buffered 2bpp framebuffer.
//   clk, rst    : clock, async active-low reset
//   lcd         : stream in / framebuffer write out (slave side)
//   err_clr     : clears sticky error flags (a new error wins)
//   fb_front    : bank holding the last complete frame
//   frame_done  : one-cycle pulse on frame commit
//   err_short   : sticky, a line ended before H_PIXELS pixels
//   err_long    : sticky, pixel dropped outside the active area
//   err_frame   : sticky, vsync arrived with line count != V_LINES
module lcd_capture
    import lcd_capture_pkg::*;
#(
    parameter int unsigned H_PIXELS = DEF_H_PIXELS,
    parameter int unsigned V_LINES  = DEF_V_LINES
) (
    input  logic          clk,
    input  logic          rst,
    lcd_capture_if.slave  lcd,
    input  logic          err_clr,
    output logic          fb_front,
    output logic          frame_done,
    output logic          err_short,
    output logic          err_long,
    output logic          err_frame
);

    localparam int unsigned X_W = $clog2(H_PIXELS + 1);
    localparam logic [X_W-1:0]   X_MAX      = X_W'(H_PIXELS);
    localparam logic [Y_W-1:0]   Y_FULL     = Y_W'(V_LINES);
    localparam logic [OFS_W-1:0] LINE_BYTES = OFS_W'(H_PIXELS / 4);

    cap_state_t       state;
    logic             vs_q;
    logic             hs_q;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [OFS_W-1:0] line_base;
    logic             wr_bank;

    logic             vs_rise_c;
    logic             hs_rise_c;
    logic             capturing_c;
    logic             in_frame_c;
    logic             push_c;
    logic             drop_c;
    logic             flush_c;
    logic [X_W-1:0]   x_next_c;
    logic [OFS_W-1:0] offset_c;
    logic             frame_ok_c;
    logic             short_set_c;
    logic             commit_c;
    logic             frame_set_c;
    logic             emit_c;
    logic [7:0]       byte_c;

    // Event decode; pixel is handled first, then the line/frame boundary.
    always_comb begin
        vs_rise_c   = lcd.lcd_vsync & ~vs_q;
        hs_rise_c   = lcd.lcd_hsync & ~hs_q;
        capturing_c = (state == CAPTURE);
        in_frame_c  = (x < X_MAX) && (y < Y_FULL);
        push_c      = capturing_c & lcd.lcd_pixel & in_frame_c;
        drop_c      = capturing_c & lcd.lcd_pixel & ~in_frame_c;
        flush_c     = capturing_c & (vs_rise_c | hs_rise_c);
        x_next_c    = x + X_W'(push_c);
        // x before this pixel's increment indexes the byte being completed.
        offset_c    = line_base + OFS_W'(x >> 2);
        frame_ok_c  = (y == Y_FULL);
        short_set_c = capturing_c & hs_rise_c & ~vs_rise_c & (x_next_c < X_MAX);
        commit_c    = capturing_c & vs_rise_c & frame_ok_c;
        frame_set_c = capturing_c & vs_rise_c & ~frame_ok_c;
    end

    px_pack4 u_pack (
        .clk    (clk),
        .rst    (rst),
        .push   (push_c),
        .flush  (flush_c),
        .color  (lcd.lcd_color),
        .emit_c (emit_c),
        .byte_c (byte_c)
    );

    // FSM, counters, bank and error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= WAIT_VSYNC;
            vs_q        <= 1'b1;
            hs_q        <= 1'b1;
            x           <= '0;
            y           <= '0;
            line_base   <= '0;
            wr_bank     <= 1'b0;
            lcd.fb_we   <= 1'b0;
            lcd.fb_addr <= '0;
            lcd.fb_data <= 8'd0;
            frame_done  <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            vs_q       <= lcd.lcd_vsync;
            hs_q       <= lcd.lcd_hsync;
            lcd.fb_we  <= emit_c;
            if (emit_c) begin
                lcd.fb_addr <= {wr_bank, offset_c};
                lcd.fb_data <= byte_c;
            end
            frame_done <= commit_c;
            err_short  <= short_set_c | (err_short & ~err_clr);
            err_long   <= drop_c      | (err_long  & ~err_clr);
            err_frame  <= frame_set_c | (err_frame & ~err_clr);

            case (state)
                WAIT_VSYNC: begin
                    if (vs_rise_c) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vs_rise_c) begin
                        if (frame_ok_c) begin
                            wr_bank <= ~wr_bank;
                        end
                        x         <= '0;
                        y         <= '0;
                        line_base <= '0;
                    end else if (hs_rise_c) begin
                        x <= '0;
                        if (y != '1) begin
                            y <= y + Y_W'(1);
                        end
                        // Stop advancing past the last line so the base never wraps.
                        if (y < Y_FULL) begin
                            line_base <= line_base + LINE_BYTES;
                        end
                    end else begin
                        x <= x_next_c;
                    end
                end
            endcase
        end
    end

    assign fb_front = ~wr_bank;

endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture: vector table, directed frame tests and randomized
// frames, all checked every cycle against a pixel-list reference model.
module tb_lcd_capture;
    import lcd_capture_pkg::*;

    localparam int H = 160;
    localparam int V = 144;

    logic clk = 1'b0;
    logic rst;
    logic err_clr, fb_front, frame_done, err_short, err_long, err_frame;

    always #5 clk = ~clk;

    lcd_capture_if bus ();

    lcd_capture dut (
        .clk        (clk),
        .rst        (rst),
        .lcd        (bus),
        .err_clr    (err_clr),
        .fb_front   (fb_front),
        .frame_done (frame_done),
        .err_short  (err_short),
        .err_long   (err_long),
        .err_frame  (err_frame)
    );

    int total = 0;
    int bad   = 0;
    int cycn  = 0;

    // observation statistics
    int          n_we, n_fd, n_not1b, n_seq_bad;
    logic [13:0] last_addr;
    logic [7:0]  last_data;
    int          lc[$];
    bit          vsl;

    // reference model state
    bit m_cap, m_vsq, m_hsq, m_bank, m_es, m_el, m_ef;
    int m_x, m_y;
    int pend[$];
    bit e_we, e_fd;
    int e_addr, e_data;

    typedef struct {
        bit vs; bit hs; bit pix; int col; bit clr;
        bit we; int addr; int data; int errs;
    } vec_t;
    vec_t tbl[15];

    function automatic vec_t mk(bit vs, bit hs, bit pix, int col, bit clr,
                                bit we, int addr, int data, int errs);
        vec_t v;
        v.vs = vs; v.hs = hs; v.pix = pix; v.col = col; v.clr = clr;
        v.we = we; v.addr = addr; v.data = data; v.errs = errs;
        return v;
    endfunction

    function automatic void model_reset();
        m_cap = 0; m_vsq = 1; m_hsq = 1; m_bank = 0;
        m_es = 0; m_el = 0; m_ef = 0;
        m_x = 0; m_y = 0; pend.delete();
        e_we = 0; e_fd = 0; e_addr = 0; e_data = 0;
    endfunction

    // Line/frame behaviour from the pixel list: byte k of line y lands at bank*8192 + y*40 + k.
    function automatic void model_step(bit vs, bit hs, bit pix, int col, bit clr);
        bit vr, hr;
        bit s_set = 0, l_set = 0, f_set = 0;
        vr = vs && !m_vsq;
        hr = hs && !m_hsq;
        m_vsq = vs; m_hsq = hs;
        e_we = 0; e_fd = 0;
        if (!m_cap) begin
            if (vr) m_cap = 1;
        end else begin
            if (pix) begin
                if (m_x < H && m_y < V) begin
                    pend.push_back(col);
                    m_x++;
                end else begin
                    l_set = 1;
                end
            end
            if (pend.size() > 0 && (vr || hr || pend.size() == 4)) begin
                e_data = 0;
                foreach (pend[i]) e_data += pend[i] << (6 - 2 * i);
                e_addr = int'(m_bank) * 8192 + m_y * (H / 4) + (m_x - 1) / 4;
                e_we = 1;
                pend.delete();
            end
            if (vr) begin
                if (m_y == V) begin
                    m_bank = ~m_bank;
                    e_fd = 1;
                end else begin
                    f_set = 1;
                end
                m_x = 0; m_y = 0;
            end else if (hr) begin
                if (m_x < H) s_set = 1;
                m_x = 0;
                if (m_y < 255) m_y++;
            end
        end
        m_es = s_set || (m_es && !clr);
        m_el = l_set || (m_el && !clr);
        m_ef = f_set || (m_ef && !clr);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cycn, got, exp);
        end
    endtask

    task automatic check_model();
        logic [27:0] g, x;
        g = {bus.fb_we, bus.fb_we ? bus.fb_addr : 14'd0, bus.fb_we ? bus.fb_data : 8'd0,
             frame_done, err_short, err_long, err_frame, fb_front};
        x = {e_we, e_we ? 14'(e_addr) : 14'd0, e_we ? 8'(e_data) : 8'd0,
             e_fd, m_es, m_el, m_ef, ~m_bank};
        chk("model", 64'(g), 64'(x));
        if (bus.fb_we === 1'b1) begin
            if (int'(bus.fb_addr) != n_we) n_seq_bad++;
            if (bus.fb_data != 8'h1B) n_not1b++;
            last_addr = bus.fb_addr;
            last_data = bus.fb_data;
            n_we++;
        end
        if (frame_done === 1'b1) n_fd++;
    endtask

    task automatic clear_stats();
        n_we = 0; n_fd = 0; n_not1b = 0; n_seq_bad = 0;
    endtask

    task automatic cyc(input bit vs, input bit hs, input bit pix, input int col, input bit clr);
        logic [1:0] cb;
        cb = col[1:0];
        bus.lcd_vsync = vs;
        bus.lcd_hsync = hs;
        bus.lcd_pixel = pix;
        bus.lcd_color = lcd_shade_t'(cb);
        err_clr = clr;
        model_step(vs, hs, pix, col, clr);
        @(posedge clk);
        @(negedge clk);
        cycn++;
        check_model();
    endtask

    task automatic do_reset(input bit vs);
        bus.lcd_vsync = vs;
        bus.lcd_hsync = 1'b0;
        bus.lcd_pixel = 1'b0;
        bus.lcd_color = SHADE_0;
        err_clr = 1'b0;
        rst = 1'b0;
        model_reset();
        #2;
        chk("reset", 64'({bus.fb_we, bus.fb_addr, bus.fb_data, frame_done,
                          err_short, err_long, err_frame, fb_front}), 64'd1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic bit rclr(bit en);
        return en && ($urandom_range(0, 63) == 0);
    endfunction

    // One line: npix strobes, optional idle gaps, hsync with the last pixel or after it.
    task automatic send_line(input int npix, input bit rnd, input bit gaps, input bit hs_last);
        int c;
        bit last;
        lc.delete();
        for (int i = 0; i < npix; i++) begin
            c = rnd ? int'($urandom_range(0, 3)) : (i % 4);
            lc.push_back(c);
            if (gaps && $urandom_range(0, 7) == 0) cyc(vsl, 0, 0, 0, rclr(gaps));
            last = (i == npix - 1);
            cyc(vsl, hs_last && last, 1, c, rclr(gaps));
        end
        if (!(hs_last && npix > 0)) cyc(vsl, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        err_clr = 1'b0;
        vsl = 0;
        clear_stats();

        tbl[0]  = mk(0, 0, 0, 0, 0,  0, 0,  0,     0);
        tbl[1]  = mk(1, 0, 0, 0, 0,  0, 0,  0,     0);
        tbl[2]  = mk(1, 0, 1, 3, 0,  0, 0,  0,     0);
        tbl[3]  = mk(1, 0, 1, 2, 0,  0, 0,  0,     0);
        tbl[4]  = mk(1, 0, 1, 1, 0,  0, 0,  0,     0);
        tbl[5]  = mk(1, 0, 1, 0, 0,  1, 0,  'hE4,  0);
        tbl[6]  = mk(1, 0, 1, 1, 0,  0, 0,  0,     0);
        tbl[7]  = mk(1, 1, 0, 0, 0,  1, 1,  'h40,  4);
        tbl[8]  = mk(1, 0, 0, 0, 1,  0, 0,  0,     0);
        tbl[9]  = mk(1, 0, 1, 2, 0,  0, 0,  0,     0);
        tbl[10] = mk(0, 0, 1, 3, 0,  0, 0,  0,     0);
        tbl[11] = mk(1, 0, 0, 0, 0,  1, 40, 'hB0,  1);
        tbl[12] = mk(1, 0, 1, 1, 0,  0, 0,  0,     1);
        tbl[13] = mk(1, 1, 0, 0, 1,  1, 0,  'h40,  4);
        tbl[14] = mk(1, 0, 0, 0, 0,  0, 0,  0,     4);

        // vector table from a fresh reset
        do_reset(0);
        foreach (tbl[i]) begin
            logic [24:0] g, x;
            cyc(tbl[i].vs, tbl[i].hs, tbl[i].pix, tbl[i].col, tbl[i].clr);
            g = {bus.fb_we, bus.fb_we ? bus.fb_addr : 14'd0, bus.fb_we ? bus.fb_data : 8'd0,
                 err_short, err_long, err_frame};
            x = {tbl[i].we, tbl[i].we ? 14'(tbl[i].addr) : 14'd0,
                 tbl[i].we ? 8'(tbl[i].data) : 8'd0, 3'(tbl[i].errs)};
            chk($sformatf("vec%0d", i), 64'(g), 64'(x));
        end

        // full frame of 0,1,2,3 into bank 0
        do_reset(0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        clear_stats();
        for (int y = 0; y < V; y++) send_line(H, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_writes", 64'(n_we), 64'd5760);
        chk("t1_seq", 64'(n_seq_bad), 64'd0);
        chk("t1_data", 64'(n_not1b), 64'd0);
        chk("t1_last", 64'(last_addr), 64'd5759);
        chk("t1_fd", 64'(n_fd), 64'd1);
        chk("t1_front", 64'(fb_front), 64'd0);
        chk("t1_errs", 64'({err_short, err_long, err_frame}), 64'd0);

        // 158-pixel line: zero-padded last byte, short error
        clear_stats();
        send_line(158, 1, 0, 0);
        chk("t2_writes", 64'(n_we), 64'd40);
        chk("t2_data", 64'(last_data), 64'((lc[156] << 6) | (lc[157] << 4)));
        chk("t2_addr", 64'(last_addr), 64'(8192 + 39));
        chk("t2_short", 64'(err_short), 64'd1);
        cyc(0, 0, 0, 0, 1);
        chk("t2_clr", 64'(err_short), 64'd0);

        // 162-pixel line: last two dropped
        clear_stats();
        send_line(162, 1, 0, 0);
        chk("t3_writes", 64'(n_we), 64'd40);
        chk("t3_addr", 64'(last_addr), 64'(8192 + 79));
        chk("t3_long", 64'(err_long), 64'd1);
        chk("t3_short", 64'(err_short), 64'd0);
        cyc(0, 0, 0, 0, 1);

        // vsync after 100 lines: aborted frame, bank kept
        for (int y = 2; y < 100; y++) send_line(8, 1, 0, 0);
        clear_stats();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_frame", 64'(err_frame), 64'd1);
        chk("t4_fd", 64'(n_fd), 64'd0);
        chk("t4_front", 64'(fb_front), 64'd0);

        // random full frame, ends with vsync and hsync together
        clear_stats();
        for (int y = 0; y < V; y++) send_line(H, 1, 1, 1'($urandom_range(0, 1)));
        cyc(0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_rwrites", 64'(n_we), 64'd5760);
        chk("t4_rfd", 64'(n_fd), 64'd1);
        chk("t4_rfront", 64'(fb_front), 64'd1);
        chk("t5_vshs_errs", 64'({err_short, err_long, err_frame}), 64'd0);

        // 4th pixel coinciding with hsync
        clear_stats();
        send_line(4, 0, 0, 1);
        chk("t5_one", 64'(n_we), 64'd1);
        chk("t5_addr0", 64'(last_addr), 64'd0);
        chk("t5_data", 64'(last_data), 64'h1B);
        send_line(4, 0, 0, 1);
        chk("t5_addr40", 64'(last_addr), 64'd40);

        // reset mid-line with vsync held high
        cyc(1, 0, 0, 0, 0);
        vsl = 1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 2, 0);
        do_reset(1);
        clear_stats();
        send_line(8, 0, 0, 0);
        chk("t6_idle_we", 64'(n_we), 64'd0);
        chk("t6_idle_err", 64'({err_short, err_long, err_frame}), 64'd0);
        vsl = 0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        vsl = 1;
        send_line(6, 0, 0, 0);
        chk("t6_writes", 64'(n_we), 64'd2);
        chk("t6_addr", 64'(last_addr), 64'd1);
        chk("t6_data", 64'(last_data), 64'h10);
        chk("t6_short", 64'(err_short), 64'd1);
        cyc(1, 0, 0, 0, 1);
        chk("t6_clr", 64'({err_short, err_long, err_frame}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
